// File: rtl/feedback_step_gen_v2.sv
// feedback_step_gen_v2: closed-loop feedback step generator.
// Integrates the registered error on i_trig and emits a shifted, saturated step
// on i_trig_dly. A constant-step mode hands back to integration without a jump
// by preloading the accumulator from the current step.
// Optional debug outputs are enabled by the macro FB_STEP_DBG_EN.
module feedback_step_gen_v2 #(
    parameter int DW       = 32,
    parameter int AW       = 40,
    parameter int SHW      = 5,
    parameter int GAIN_RST = 5
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_trig,
    input  logic                 i_trig_dly,
    input  logic signed [DW-1:0] i_err,
    input  logic        [31:0]   i_gain_sel,
    input  logic        [31:0]   i_fb_ON,
    input  logic signed [DW-1:0] i_const_step,
    input  logic                 i_clr,
    output logic signed [DW-1:0] o_step,
    output logic                 o_step_vld,
    output logic                 o_sat
`ifdef FB_STEP_DBG_EN
    ,
    output logic signed [AW-1:0] o_acc_q,
    output logic [SHW-1:0]       o_gain_lat_q,
    output logic [1:0]           o_state_q,
    output logic [15:0]          o_drop_cnt
`endif
);

    localparam logic [1:0] S_OFF   = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_CONST = 2'd3;

    // Wide enough to hold a DW value sign-extended into AW bits and shifted by
    // the largest possible gain, so preload overflow can be detected exactly.
    localparam int PW = AW + (1 << SHW);

    localparam logic signed [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic signed [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};
    localparam logic signed [DW-1:0] OUT_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] OUT_MIN = {1'b1, {(DW-1){1'b0}}};

    // Registered state
    logic signed [DW-1:0] err_q;
    logic [SHW-1:0]       gain_q;
    logic [1:0]           mode_q;
    logic [1:0]           state_q,    state_d;
    logic signed [AW-1:0] acc_q,      acc_d;
    logic [SHW-1:0]       gain_lat_q, gain_lat_d;
    logic signed [DW-1:0] step_q,     step_d;
    logic                 vld_q,      vld_d;
    logic                 sat_q,      sat_d;

    // Upper select bits carry no meaning for this block.
    logic unused_sel_bits;
    assign unused_sel_bits = ^{i_gain_sel[31:SHW], i_fb_ON[31:2]};

    // Shift amounts beyond AW-1 would shift out every bit; cap them.
    function automatic logic [SHW-1:0] clamp_gain(input logic [SHW-1:0] g);
        if (int'(g) > AW - 1)
            return SHW'(AW - 1);
        return g;
    endfunction

    // Accumulate path: one guard bit catches overflow of acc + err.
    logic [AW:0]          acc_sum;
    logic                 acc_ovf;
    logic signed [AW-1:0] acc_add_sat;
    assign acc_sum     = {acc_q[AW-1], acc_q} + {{(AW+1-DW){err_q[DW-1]}}, err_q};
    assign acc_ovf     = acc_sum[AW] ^ acc_sum[AW-1];
    assign acc_add_sat = acc_ovf ? (acc_sum[AW] ? ACC_MIN : ACC_MAX) : acc_sum[AW-1:0];

    // Bumpless preload: current step scaled back up by the present gain.
    logic signed [PW-1:0] pre_ext;
    logic signed [PW-1:0] pre_wide;
    logic                 pre_ovf;
    logic signed [AW-1:0] pre_sat;
    assign pre_ext  = {{(PW-DW){step_q[DW-1]}}, step_q};
    assign pre_wide = pre_ext <<< gain_q;
    assign pre_ovf  = pre_wide[PW-1:AW-1] != {(PW-AW+1){pre_wide[PW-1]}};
    assign pre_sat  = pre_ovf ? (pre_wide[PW-1] ? ACC_MIN : ACC_MAX) : pre_wide[AW-1:0];

    // Output path: arithmetic shift by the gain latched at the last i_trig.
    logic signed [AW-1:0] out_sh;
    logic                 out_ovf;
    logic signed [DW-1:0] out_sat;
    assign out_sh  = acc_q >>> gain_lat_q;
    assign out_ovf = out_sh[AW-1:DW-1] != {(AW-DW+1){out_sh[AW-1]}};
    assign out_sat = out_ovf ? (out_sh[AW-1] ? OUT_MIN : OUT_MAX) : out_sh[DW-1:0];

    logic drop_evt;

    // Next-state logic: clear first, then mode decode, then strobe handling.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        gain_lat_d = gain_lat_q;
        step_d     = step_q;
        vld_d      = 1'b0;
        sat_d      = sat_q;
        drop_evt   = 1'b0;
        if (i_clr) begin
            acc_d  = '0;
            step_d = '0;
            sat_d  = 1'b0;
            if (mode_q == 2'd1)
                state_d = S_WAIT;
        end else begin
            case (mode_q)
                2'd1: begin
                    case (state_q)
                        S_OFF: state_d = S_WAIT;
                        S_CONST: begin
                            acc_d      = pre_sat;
                            gain_lat_d = clamp_gain(gain_q);
                            if (pre_ovf)
                                sat_d = 1'b1;
                            state_d    = S_HOLD;
                        end
                        default: begin
                            if (i_trig) begin
                                acc_d      = acc_add_sat;
                                gain_lat_d = clamp_gain(gain_q);
                                if (acc_ovf)
                                    sat_d = 1'b1;
                                state_d    = S_HOLD;
                                drop_evt   = i_trig_dly;
                            end else if (i_trig_dly) begin
                                if (state_q == S_HOLD) begin
                                    step_d  = out_sat;
                                    vld_d   = 1'b1;
                                    if (out_ovf)
                                        sat_d = 1'b1;
                                    state_d = S_WAIT;
                                end else begin
                                    drop_evt = 1'b1;
                                end
                            end
                        end
                    endcase
                end
                2'd2: begin
                    if (state_q != S_CONST) begin
                        state_d = S_CONST;
                        acc_d   = '0;
                    end else if (i_trig) begin
                        step_d = i_const_step;
                        vld_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = S_OFF;
                    acc_d   = '0;
                    step_d  = '0;
                end
            endcase
        end
    end

    // State and input registers with asynchronous reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            err_q      <= '0;
            gain_q     <= SHW'(GAIN_RST);
            mode_q     <= 2'd0;
            state_q    <= S_OFF;
            acc_q      <= '0;
            gain_lat_q <= SHW'(GAIN_RST);
            step_q     <= '0;
            vld_q      <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            err_q      <= i_err;
            gain_q     <= i_gain_sel[SHW-1:0];
            mode_q     <= i_fb_ON[1:0];
            state_q    <= state_d;
            acc_q      <= acc_d;
            gain_lat_q <= gain_lat_d;
            step_q     <= step_d;
            vld_q      <= vld_d;
            sat_q      <= sat_d;
        end
    end

    assign o_step     = step_q;
    assign o_step_vld = vld_q;
    assign o_sat      = sat_q;

`ifdef FB_STEP_DBG_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // Saturating count of discarded output strobes.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (i_clr)
            drop_cnt_d = '0;
        else if (drop_evt && (drop_cnt_q != 16'hFFFF))
            drop_cnt_d = drop_cnt_q + 16'd1;
    end

    // Drop counter register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            drop_cnt_q <= '0;
        else
            drop_cnt_q <= drop_cnt_d;
    end

    assign o_acc_q      = acc_q;
    assign o_gain_lat_q = gain_lat_q;
    assign o_state_q    = state_q;
    assign o_drop_cnt   = drop_cnt_q;
`else
    logic unused_drop_evt;
    assign unused_drop_evt = drop_evt;
`endif

endmodule

// File: tb/tb_feedback_step_gen_v2.sv
// Scoreboard bench for feedback_step_gen_v2: directed stimulus pushes expected
// steps; a negedge monitor pops one entry per o_step_vld pulse.
module tb_feedback_step_gen_v2;
    localparam int DW  = 32;
    localparam int AW  = 40;
    localparam int SHW = 5;

    logic                 clk    = 1'b0;
    logic                 rst_n  = 1'b0;
    logic                 trig   = 1'b0;
    logic                 dly    = 1'b0;
    logic                 clr    = 1'b0;
    logic signed [DW-1:0] err    = '0;
    logic signed [DW-1:0] cst    = '0;
    logic [31:0]          gain   = 32'd5;
    logic [31:0]          mode   = 32'd0;
    logic signed [DW-1:0] step;
    logic                 vld;
    logic                 sat;
`ifdef FB_STEP_DBG_EN
    logic signed [AW-1:0] dbg_acc;
    logic [SHW-1:0]       dbg_gain_lat;
    logic [1:0]           dbg_state;
    logic [15:0]          dbg_drop;
`endif

    typedef struct packed {
        logic signed [DW-1:0] step;
        logic                 sat;
    } exp_t;

    exp_t exp_q[$];
    int   pass_cnt = 0;
    int   chk_cnt  = 0;

    always #5 clk = ~clk;

    feedback_step_gen_v2 #(.DW(DW), .AW(AW), .SHW(SHW), .GAIN_RST(5)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_trig       (trig),
        .i_trig_dly   (dly),
        .i_err        (err),
        .i_gain_sel   (gain),
        .i_fb_ON      (mode),
        .i_const_step (cst),
        .i_clr        (clr),
        .o_step       (step),
        .o_step_vld   (vld),
        .o_sat        (sat)
`ifdef FB_STEP_DBG_EN
        ,
        .o_acc_q      (dbg_acc),
        .o_gain_lat_q (dbg_gain_lat),
        .o_state_q    (dbg_state),
        .o_drop_cnt   (dbg_drop)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        chk_cnt++;
        if (act === req) begin
            pass_cnt++;
            $display("ok   %s: 0x%0h", name, act);
        end else begin
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_trig();
        trig = 1'b1;
        tick(1);
        trig = 1'b0;
    endtask

    task automatic pulse_dly();
        dly = 1'b1;
        tick(1);
        dly = 1'b0;
        tick(1);
    endtask

    task automatic expect_step(input logic signed [DW-1:0] s, input logic f);
        exp_t e;
        e.step = s;
        e.sat  = f;
        exp_q.push_back(e);
    endtask

    // Monitor: every vld pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && vld) begin
            if (exp_q.size() == 0) begin
                check("unexpected_vld", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("step", step, e.step);
                check("sat", sat, e.sat);
            end
        end
    end

    initial begin
        // Reset state
        tick(2);
        check("rst_step", step, 0);
        check("rst_vld", vld, 0);
        check("rst_sat", sat, 0);
        rst_n = 1'b1;
        tick(1);

        // Integrate basic: gain 2, err 100
        mode = 32'd1; gain = 32'd2; err = 100;
        tick(2);
        for (int k = 1; k <= 4; k++) begin
            pulse_trig();
            expect_step(25 * k, 1'b0);
            pulse_dly();
        end
        check("int_sat", sat, 0);

        // Gain latch
        clr = 1'b1; tick(1); clr = 1'b0;
        gain = 32'd0; err = 8;
        tick(1);
        pulse_trig();
        gain = 32'd3;
        tick(1);
        expect_step(8, 1'b0);
        pulse_dly();
        pulse_trig();
        expect_step(2, 1'b0);
        pulse_dly();

        // Output saturation then clear
        clr = 1'b1; tick(1); clr = 1'b0;
        gain = 32'd0; err = 32'sh7FFFFFFF;
        tick(1);
        pulse_trig();
        expect_step(32'sh7FFFFFFF, 1'b0);
        pulse_dly();
        pulse_trig();
        expect_step(32'sh7FFFFFFF, 1'b1);
        pulse_dly();
        clr = 1'b1; tick(1); clr = 1'b0;
        check("clr_step", step, 0);
        check("clr_sat", sat, 0);

        // Constant mode and bumpless transfer
        mode = 32'd2; cst = -40;
        tick(2);
        expect_step(-40, 1'b0);
        pulse_trig();
        tick(1);
        mode = 32'd1; gain = 32'd4;
        tick(2);
`ifdef FB_STEP_DBG_EN
        check("preload_acc", dbg_acc, -640);
`endif
        expect_step(-40, 1'b0);
        pulse_dly();

        // Strobe conflict: trig wins, then dly in S_WAIT ignored
        err = 16;
        tick(1);
        trig = 1'b1; dly = 1'b1;
        tick(1);
        trig = 1'b0; dly = 1'b0;
        tick(1);
        check("conflict_step", step, -40);
        expect_step(-39, 1'b0);
        pulse_dly();
        pulse_dly();
        check("wait_dly_step", step, -39);
`ifdef FB_STEP_DBG_EN
        check("drop_cnt", dbg_drop, 2);
`endif

        // Mode off mid-period
        pulse_trig();
        mode = 32'd3;
        tick(2);
        check("off_step", step, 0);
`ifdef FB_STEP_DBG_EN
        check("off_acc", dbg_acc, 0);
`endif

        // Asynchronous reset in S_HOLD
        mode = 32'd1; gain = 32'd1; err = 100;
        tick(2);
        pulse_trig();
        #3 rst_n = 1'b0;
        #1;
        check("arst_step", step, 0);
        check("arst_vld", vld, 0);
        check("arst_sat", sat, 0);
`ifdef FB_STEP_DBG_EN
        check("arst_gain_lat", dbg_gain_lat, 5);
        check("arst_state", dbg_state, 0);
`endif
        tick(1);
        rst_n = 1'b1;
        pulse_dly();
        check("post_rst_step", step, 0);

        tick(2);
        check("queue_drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
